rename_reg_file: RTL and testbench
==================================

// Module: rename_reg_file
// PURPOSE
// - Parametrised architectural register file with rename tracking: per-register value, busy bit, owner tag.
// - Serves operand reads from the instruction buffer, takes allocations from dispatch and writes from retirement.
// - Adds allocate ports, tag-qualified busy release, flush recovery and optional retire-to-read bypass.
// - Sits between the dispatch/instruction buffer and the retirement stage.
// PARAMETERS
// - NUM_REGS    16  architectural registers; ADDR_W = $clog2(NUM_REGS)
// - DATA_W      16  register value width
// - TAG_W       4   owner (ROB) tag width
// - NUM_RD      8   read ports
// - NUM_RET     3   retirement write ports
// - NUM_ALLOC   2   dispatch allocate ports
// - BYPASS      1   1: same-cycle retire writes forwarded to reads; 0: no forwarding
// PORTS (port k occupies slice [k*W +: W] of each flattened vector)
// - clk          in   1                         clock, rising edge
// - rst          in   1                         asynchronous, active-high reset
// - rd_addr      in   NUM_RD*ADDR_W             read addresses
// - rd_data      out  NUM_RD*(DATA_W+1+TAG_W)   read result {value, busy, owner}
// - ret_valid    in   NUM_RET                   retirement write strobes
// - ret_addr     in   NUM_RET*ADDR_W            retiring destination register
// - ret_tag      in   NUM_RET*TAG_W             tag of retiring instruction
// - ret_data     in   NUM_RET*DATA_W            retiring value
// - alloc_valid  in   NUM_ALLOC                 dispatch allocate strobes
// - alloc_addr   in   NUM_ALLOC*ADDR_W          destination register being renamed
// - alloc_tag    in   NUM_ALLOC*TAG_W           new owner tag
// - flush        in   1                         clear all busy bits (mispredict recovery)
// - busy_cnt     out  ADDR_W+1                  registered count of busy registers
// BEHAVIOUR
// - Reset (async, immediate): all values, busy bits, owners = 0; rd_data = 0; busy_cnt = 0.
// - Read: latency 1; rd_data registered on clk from rd_addr sampled that edge.
//   BYPASS=0: returns state before this cycle's updates.
//   BYPASS=1: returns post-update value/busy/owner for every field touched this cycle (retire, alloc, flush).
// - Retire port j with ret_valid[j]: value[ret_addr] <= ret_data unconditionally;
//   busy cleared only if owner[ret_addr] == ret_tag (younger rename keeps busy=1).
// - Alloc port k with alloc_valid[k]: busy[alloc_addr] <= 1, owner <= alloc_tag; value untouched.
// - Priority, same register same cycle: alloc beats retire for busy/owner (value still written);
//   among retire ports highest index wins; among alloc ports highest index wins.
// - Retire tag compare uses owner before this cycle's allocs.
// - flush: all busy <= 0 next cycle; allocs that cycle discarded; retire value writes still performed.
// - busy_cnt: popcount of busy array after this cycle's update, registered; range 0..NUM_REGS.
// - No handshake/backpressure: every port accepted every cycle; invalid strobes are no-ops.
// STRUCTURE
// - Shared package rrf_pkg: ADDR_W/TAG_W/DATA_W defaults, RD_W = DATA_W+1+TAG_W,
//   function pack_rd(value,busy,owner), localparam field offsets for rd_data.
// - One sub-module rrf_next_state: combinational next value/busy/owner per register from
//   retire/alloc/flush; feeds both the state flops and the BYPASS read mux.
// - Top: state flops with async reset, NUM_RD read muxes, popcount for busy_cnt.
// TESTING
// - Reset mid-run: busy regs 3,5 set, assert rst -> rd_data, busy_cnt = 0 same cycle, all reads {0,0,0} after.
// - Alloc r2 tag 7, next cycle read r2 -> {0x0000,1,7}; retire r2 tag 7 data 0xBEEF -> read {0xBEEF,0,7}.
// - Stale retire: alloc r4 tag 1 then tag 2; retire r4 tag 1 data 0x1234 -> {0x1234,1,2}, busy_cnt unchanged.
// - Same-cycle collision: retire r6 tag 3 (owner 3) + alloc r6 tag 9 -> {retired data,1,9}; two retires r1 data 0xA/0xB on ports 0/2 -> 0xB.
// - BYPASS=1: retire r8 data 0x55AA while reading r8 -> rd_data next edge {0x55AA,0,owner}; BYPASS=0 -> old value.
// - Flush with 5 busy regs plus alloc r0 tag 4 same cycle -> busy_cnt 0, r0 read {value,0,old owner}.

Source files
------------

// File: rtl/rrf_pkg.sv
// Shared defaults, read-result layout and packing helper for the rename register file.
package rrf_pkg;

    localparam int RRF_NUM_REGS = 16;
    localparam int RRF_ADDR_W   = $clog2(RRF_NUM_REGS);
    localparam int RRF_DATA_W   = 16;
    localparam int RRF_TAG_W    = 4;

    // Read result is {value, busy, owner} with owner in the LSBs.
    localparam int RD_W         = RRF_DATA_W + 1 + RRF_TAG_W;
    localparam int RD_OWNER_LSB = 0;
    localparam int RD_BUSY_BIT  = RRF_TAG_W;
    localparam int RD_VALUE_LSB = RRF_TAG_W + 1;

    typedef struct packed {
        logic [RRF_DATA_W-1:0] value;
        logic                  busy;
        logic [RRF_TAG_W-1:0]  owner;
    } rrf_entry_t;

    function automatic logic [RD_W-1:0] pack_rd(
        input logic [RRF_DATA_W-1:0] value,
        input logic                  busy,
        input logic [RRF_TAG_W-1:0]  owner
    );
        return {value, busy, owner};
    endfunction

endpackage

// File: rtl/rrf_next_state.sv
// Combinational next value/busy/owner for every register from retire, allocate and flush.
module rrf_next_state
    import rrf_pkg::*;
#(
    parameter int NUM_REGS  = RRF_NUM_REGS,
    parameter int ADDR_W    = RRF_ADDR_W,
    parameter int DATA_W    = RRF_DATA_W,
    parameter int TAG_W     = RRF_TAG_W,
    parameter int NUM_RET   = 3,
    parameter int NUM_ALLOC = 2
) (
    input  logic [DATA_W-1:0]           value_cur [NUM_REGS],
    input  logic [NUM_REGS-1:0]         busy_cur,
    input  logic [TAG_W-1:0]            owner_cur [NUM_REGS],
    input  logic [NUM_RET-1:0]          ret_valid,
    input  logic [NUM_RET*ADDR_W-1:0]   ret_addr,
    input  logic [NUM_RET*TAG_W-1:0]    ret_tag,
    input  logic [NUM_RET*DATA_W-1:0]   ret_data,
    input  logic [NUM_ALLOC-1:0]        alloc_valid,
    input  logic [NUM_ALLOC*ADDR_W-1:0] alloc_addr,
    input  logic [NUM_ALLOC*TAG_W-1:0]  alloc_tag,
    input  logic                        flush,
    output logic [DATA_W-1:0]           value_nxt [NUM_REGS],
    output logic [NUM_REGS-1:0]         busy_nxt,
    output logic [TAG_W-1:0]            owner_nxt [NUM_REGS]
);

    // Later ports overwrite earlier ones, so the highest index wins; allocs are applied
    // after retires so a same-cycle rename keeps the register busy under its new tag.
    // The retire tag check always looks at the owner from before this cycle.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            value_nxt[r] = value_cur[r];
            busy_nxt[r]  = busy_cur[r];
            owner_nxt[r] = owner_cur[r];
            for (int j = 0; j < NUM_RET; j++) begin
                if (ret_valid[j] && (ret_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    value_nxt[r] = ret_data[j*DATA_W +: DATA_W];
                    if (ret_tag[j*TAG_W +: TAG_W] == owner_cur[r]) begin
                        busy_nxt[r] = 1'b0;
                    end
                end
            end
            for (int k = 0; k < NUM_ALLOC; k++) begin
                if (!flush && alloc_valid[k] && (alloc_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    busy_nxt[r]  = 1'b1;
                    owner_nxt[r] = alloc_tag[k*TAG_W +: TAG_W];
                end
            end
            if (flush) begin
                busy_nxt[r] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with rename tracking: value, busy bit and owner tag per register.
module rename_reg_file
    import rrf_pkg::*;
#(
    parameter int NUM_REGS  = RRF_NUM_REGS,
    parameter int DATA_W    = RRF_DATA_W,
    parameter int TAG_W     = RRF_TAG_W,
    parameter int NUM_RD    = 8,
    parameter int NUM_RET   = 3,
    parameter int NUM_ALLOC = 2,
    parameter int BYPASS    = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS),
    localparam int ENTRY_W  = DATA_W + 1 + TAG_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
    output logic [NUM_RD*ENTRY_W-1:0]   rd_data,
    input  logic [NUM_RET-1:0]          ret_valid,
    input  logic [NUM_RET*ADDR_W-1:0]   ret_addr,
    input  logic [NUM_RET*TAG_W-1:0]    ret_tag,
    input  logic [NUM_RET*DATA_W-1:0]   ret_data,
    input  logic [NUM_ALLOC-1:0]        alloc_valid,
    input  logic [NUM_ALLOC*ADDR_W-1:0] alloc_addr,
    input  logic [NUM_ALLOC*TAG_W-1:0]  alloc_tag,
    input  logic                        flush,
    output logic [ADDR_W:0]             busy_cnt
);

    logic [DATA_W-1:0]         value_q [NUM_REGS];
    logic [DATA_W-1:0]         value_d [NUM_REGS];
    logic [NUM_REGS-1:0]       busy_q;
    logic [NUM_REGS-1:0]       busy_d;
    logic [TAG_W-1:0]          owner_q [NUM_REGS];
    logic [TAG_W-1:0]          owner_d [NUM_REGS];
    logic [NUM_RD*ENTRY_W-1:0] rd_data_q;
    logic [NUM_RD*ENTRY_W-1:0] rd_data_d;
    logic [ADDR_W:0]           busy_cnt_q;
    logic [ADDR_W:0]           busy_cnt_d;

    rrf_next_state #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .TAG_W     (TAG_W),
        .NUM_RET   (NUM_RET),
        .NUM_ALLOC (NUM_ALLOC)
    ) u_next_state (
        .value_cur   (value_q),
        .busy_cur    (busy_q),
        .owner_cur   (owner_q),
        .ret_valid   (ret_valid),
        .ret_addr    (ret_addr),
        .ret_tag     (ret_tag),
        .ret_data    (ret_data),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_tag   (alloc_tag),
        .flush       (flush),
        .value_nxt   (value_d),
        .busy_nxt    (busy_d),
        .owner_nxt   (owner_d)
    );

    // With BYPASS the read sees this cycle's retire/alloc/flush effects; otherwise the old state.
    always_comb begin
        rd_data_d = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    if (BYPASS != 0) begin
                        rd_data_d[p*ENTRY_W +: ENTRY_W] = {value_d[r], busy_d[r], owner_d[r]};
                    end else begin
                        rd_data_d[p*ENTRY_W +: ENTRY_W] = {value_q[r], busy_q[r], owner_q[r]};
                    end
                end
            end
        end
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                value_q[r] <= '0;
                owner_q[r] <= '0;
            end
            busy_q     <= '0;
            rd_data_q  <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                value_q[r] <= value_d[r];
                owner_q[r] <= owner_d[r];
            end
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_rename_reg_file.sv
// Bench for rename_reg_file: forwarding and non-forwarding instances checked against a register-array model.
module tb_rename_reg_file;
    import rrf_pkg::*;

    localparam int NUM_REGS  = 16;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 16;
    localparam int TAG_W     = 4;
    localparam int NUM_RD    = 8;
    localparam int NUM_RET   = 3;
    localparam int NUM_ALLOC = 2;
    localparam int ENTRY_W   = DATA_W + 1 + TAG_W;
    localparam int VEC_W     = NUM_RD * ENTRY_W;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_RD*ADDR_W-1:0]    rd_addr;
    logic [NUM_RET-1:0]          ret_valid;
    logic [NUM_RET*ADDR_W-1:0]   ret_addr;
    logic [NUM_RET*TAG_W-1:0]    ret_tag;
    logic [NUM_RET*DATA_W-1:0]   ret_data;
    logic [NUM_ALLOC-1:0]        alloc_valid;
    logic [NUM_ALLOC*ADDR_W-1:0] alloc_addr;
    logic [NUM_ALLOC*TAG_W-1:0]  alloc_tag;
    logic                        flush;
    logic [VEC_W-1:0]            rd_data_bp;
    logic [VEC_W-1:0]            rd_data_nb;
    logic [ADDR_W:0]             busy_cnt_bp;
    logic [ADDR_W:0]             busy_cnt_nb;

    logic [DATA_W-1:0] m_val  [NUM_REGS];
    logic              m_busy [NUM_REGS];
    logic [TAG_W-1:0]  m_own  [NUM_REGS];
    logic [VEC_W-1:0]  exp_bp;
    logic [VEC_W-1:0]  exp_nb;
    logic [ADDR_W:0]   exp_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rename_reg_file #(.BYPASS(1)) dut_bp (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_bp),
        .ret_valid(ret_valid), .ret_addr(ret_addr), .ret_tag(ret_tag), .ret_data(ret_data),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_tag(alloc_tag),
        .flush(flush), .busy_cnt(busy_cnt_bp)
    );

    rename_reg_file #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .ret_valid(ret_valid), .ret_addr(ret_addr), .ret_tag(ret_tag), .ret_data(ret_data),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_tag(alloc_tag),
        .flush(flush), .busy_cnt(busy_cnt_nb)
    );

    task automatic check(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] port_of(input logic [VEC_W-1:0] vec, input int p);
        return vec[p*ENTRY_W +: ENTRY_W];
    endfunction

    task automatic clear_inputs();
        rd_addr     = '0;
        ret_valid   = '0;
        ret_addr    = '0;
        ret_tag     = '0;
        ret_data    = '0;
        alloc_valid = '0;
        alloc_addr  = '0;
        alloc_tag   = '0;
        flush       = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [ADDR_W-1:0] a);
        rd_addr[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic set_ret(input int j, input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t,
                           input logic [DATA_W-1:0] d);
        ret_valid[j]                = 1'b1;
        ret_addr[j*ADDR_W +: ADDR_W] = a;
        ret_tag[j*TAG_W +: TAG_W]    = t;
        ret_data[j*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_alloc(input int k, input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t);
        alloc_valid[k]                 = 1'b1;
        alloc_addr[k*ADDR_W +: ADDR_W] = a;
        alloc_tag[k*TAG_W +: TAG_W]    = t;
    endtask

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_val[r]  = '0;
            m_busy[r] = 1'b0;
            m_own[r]  = '0;
        end
    endtask

    // Applies the architectural rules to the model and derives what each instance should show.
    task automatic model_step();
        logic [TAG_W-1:0]  old_own [NUM_REGS];
        int                a;
        int                cnt;
        old_own = m_own;
        for (int p = 0; p < NUM_RD; p++) begin
            a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
            exp_nb[p*ENTRY_W +: ENTRY_W] = pack_rd(m_val[a], m_busy[a], m_own[a]);
        end
        for (int j = 0; j < NUM_RET; j++) begin
            if (ret_valid[j]) begin
                a = int'(ret_addr[j*ADDR_W +: ADDR_W]);
                m_val[a] = ret_data[j*DATA_W +: DATA_W];
                if (old_own[a] == ret_tag[j*TAG_W +: TAG_W]) m_busy[a] = 1'b0;
            end
        end
        if (!flush) begin
            for (int k = 0; k < NUM_ALLOC; k++) begin
                if (alloc_valid[k]) begin
                    a = int'(alloc_addr[k*ADDR_W +: ADDR_W]);
                    m_busy[a] = 1'b1;
                    m_own[a]  = alloc_tag[k*TAG_W +: TAG_W];
                end
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 1'b0;
        end
        cnt = 0;
        for (int r = 0; r < NUM_REGS; r++) cnt += int'(m_busy[r]);
        exp_cnt = (ADDR_W+1)'(cnt);
        for (int p = 0; p < NUM_RD; p++) begin
            a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
            exp_bp[p*ENTRY_W +: ENTRY_W] = pack_rd(m_val[a], m_busy[a], m_own[a]);
        end
    endtask

    task automatic apply_stimulus(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check($sformatf("%s rd_bp", tag), rd_data_bp, exp_bp);
        check($sformatf("%s rd_nb", tag), rd_data_nb, exp_nb);
        check($sformatf("%s cnt_bp", tag), VEC_W'(busy_cnt_bp), VEC_W'(exp_cnt));
        check($sformatf("%s cnt_nb", tag), VEC_W'(busy_cnt_nb), VEC_W'(exp_cnt));
        clear_inputs();
    endtask

    task automatic check_zero(input string tag);
        check($sformatf("%s rd_bp", tag), rd_data_bp, '0);
        check($sformatf("%s rd_nb", tag), rd_data_nb, '0);
        check($sformatf("%s cnt_bp", tag), VEC_W'(busy_cnt_bp), '0);
        check($sformatf("%s cnt_nb", tag), VEC_W'(busy_cnt_nb), '0);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        logic [TAG_W-1:0]  rt;

        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        set_alloc(0, 4'd2, 4'd7); set_rd(0, 4'd2);
        apply_stimulus("alloc r2");
        set_rd(0, 4'd2);
        apply_stimulus("read r2");
        check("r2 renamed nb", VEC_W'(port_of(rd_data_nb, 0)), VEC_W'(pack_rd(16'h0000, 1'b1, 4'd7)));

        set_ret(0, 4'd2, 4'd7, 16'hBEEF); set_rd(0, 4'd2);
        apply_stimulus("retire r2");
        set_rd(0, 4'd2);
        apply_stimulus("read r2 again");
        check("r2 retired nb", VEC_W'(port_of(rd_data_nb, 0)), VEC_W'(pack_rd(16'hBEEF, 1'b0, 4'd7)));

        set_alloc(1, 4'd4, 4'd1);
        apply_stimulus("alloc r4 t1");
        set_alloc(0, 4'd4, 4'd2);
        apply_stimulus("alloc r4 t2");
        set_ret(1, 4'd4, 4'd1, 16'h1234); set_rd(1, 4'd4);
        apply_stimulus("stale retire r4");
        check("stale retire bp", VEC_W'(port_of(rd_data_bp, 1)), VEC_W'(pack_rd(16'h1234, 1'b1, 4'd2)));
        check("stale retire cnt", VEC_W'(busy_cnt_bp), VEC_W'(1));

        set_alloc(0, 4'd6, 4'd3);
        apply_stimulus("alloc r6 t3");
        set_ret(1, 4'd6, 4'd3, 16'h0C0C); set_alloc(1, 4'd6, 4'd9);
        set_ret(0, 4'd1, 4'd0, 16'h000A); set_ret(2, 4'd1, 4'd0, 16'h000B);
        set_rd(2, 4'd6); set_rd(3, 4'd1);
        apply_stimulus("collision");
        check("alloc beats retire", VEC_W'(port_of(rd_data_bp, 2)), VEC_W'(pack_rd(16'h0C0C, 1'b1, 4'd9)));
        check("high retire port", VEC_W'(port_of(rd_data_bp, 3)), VEC_W'(pack_rd(16'h000B, 1'b0, 4'd0)));

        set_ret(0, 4'd8, 4'd0, 16'h55AA); set_rd(0, 4'd8);
        apply_stimulus("bypass r8");
        check("bypass on", VEC_W'(port_of(rd_data_bp, 0)), VEC_W'(pack_rd(16'h55AA, 1'b0, 4'd0)));
        check("bypass off", VEC_W'(port_of(rd_data_nb, 0)), VEC_W'(pack_rd(16'h0000, 1'b0, 4'd0)));

        set_alloc(0, 4'd0, 4'd5);
        apply_stimulus("alloc r0 t5");
        set_ret(0, 4'd0, 4'd5, 16'h0077);
        apply_stimulus("retire r0");
        set_alloc(0, 4'd3, 4'd1); set_alloc(1, 4'd5, 4'd2);
        apply_stimulus("alloc r3 r5");
        set_alloc(0, 4'd7, 4'd3);
        apply_stimulus("alloc r7");
        check("five busy", VEC_W'(busy_cnt_bp), VEC_W'(5));
        flush = 1'b1; set_alloc(0, 4'd0, 4'd4); set_rd(0, 4'd0);
        apply_stimulus("flush");
        check("flush cnt", VEC_W'(busy_cnt_bp), VEC_W'(0));
        check("flush drops alloc", VEC_W'(port_of(rd_data_bp, 0)), VEC_W'(pack_rd(16'h0077, 1'b0, 4'd5)));

        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < NUM_RD; p++) set_rd(p, ADDR_W'($urandom_range(0, NUM_REGS-1)));
            for (int j = 0; j < NUM_RET; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    ra = ADDR_W'($urandom_range(0, NUM_REGS-1));
                    rt = ($urandom_range(0, 1) == 1) ? m_own[ra] : TAG_W'($urandom_range(0, 15));
                    set_ret(j, ra, rt, DATA_W'($urandom));
                end
            end
            for (int k = 0; k < NUM_ALLOC; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_alloc(k, ADDR_W'($urandom_range(0, NUM_REGS-1)), TAG_W'($urandom_range(0, 15)));
                end
            end
            flush = ($urandom_range(0, 15) == 0);
            apply_stimulus("random");
        end

        set_alloc(0, 4'd3, 4'd6); set_alloc(1, 4'd5, 4'd8);
        apply_stimulus("pre-reset busy");
        #2;
        rst = 1'b1;
        #1;
        check_zero("async reset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int p = 0; p < NUM_RD; p++) set_rd(p, ADDR_W'(p));
        apply_stimulus("post reset lo");
        check("post reset lo zero", rd_data_nb, '0);
        for (int p = 0; p < NUM_RD; p++) set_rd(p, ADDR_W'(p + 8));
        apply_stimulus("post reset hi");
        check("post reset hi zero", rd_data_nb, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
